idelay_calib_sequencer: RTL and testbench

- Calibrates the per-lane IDELAY taps of the LTC2145 LVDS receiver.
- The ADC runs in alternating-bit test-pattern mode during calibration. The block calibrates one lane at a time.
- For each lane it sweeps all 32 taps, checks that every sampled bit toggles, finds the widest passing window and loads the centre tap.
- It sits in the sample_clk domain, between the IDELAYCTRL ready flag and the per-lane IDELAYE2 LD/CNTVALUEIN pins.

---
 rtl/idelay_calib_sequencer_pkg.sv | 31 +++
 rtl/idelay_window_tracker.sv | 52 +++++
 rtl/idelay_calib_sequencer.sv | 179 +++++++++++++++++
 tb/tb_idelay_calib_sequencer.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/idelay_calib_sequencer_pkg.sv
// Shared types and helpers for the LTC2145 LVDS receiver IDELAY calibration.
// Tap/window widths, the sequencer state encoding and the centre-tap helper.
// Pure package: no logic, no latency, no flow control.
package idelay_calib_sequencer_pkg;

  localparam int TAP_W    = 5;
  localparam int NUM_TAPS = 32;
  localparam int WIN_W    = 6;

  typedef enum logic [3:0] {
    IDLE,
    WAIT_RDY,
    LOAD,
    SETTLE,
    CHECK,
    EVAL,
    APPLY,
    NEXT_LANE,
    DONE
  } cal_state_t;

  // Floor centre of a window; only meaningful for len >= 1, and a window
  // never runs past tap 31, so the 5-bit sum cannot overflow.
  function automatic logic [TAP_W-1:0] centre_tap(input logic [TAP_W-1:0] start,
                                                  input logic [WIN_W-1:0] len);
    logic [WIN_W-1:0] half;
    half = (len - WIN_W'(1)) >> 1;
    return start + half[TAP_W-1:0];
  endfunction

endpackage

// File: rtl/idelay_window_tracker.sv
// Tracks the current and widest run of passing taps during one lane sweep.
// Latency: one cycle per update; centre/best_len are valid the cycle after.
// No backpressure: clear and update are single-cycle strobes from the sequencer.
module idelay_window_tracker
  import idelay_calib_sequencer_pkg::*;
(
  input  logic             sample_clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             update,
  input  logic             pass,
  input  logic [TAP_W-1:0] tap,
  output logic [WIN_W-1:0] best_len,
  output logic [TAP_W-1:0] centre
);

  logic [TAP_W-1:0] run_start;
  logic [WIN_W-1:0] run_len;
  logic [TAP_W-1:0] best_start;
  logic [TAP_W-1:0] run_start_nxt;
  logic [WIN_W-1:0] run_len_inc;

  // A new run starts at the current tap; otherwise keep the existing start.
  always_comb begin
    run_start_nxt = (run_len == '0) ? tap : run_start;
    run_len_inc   = run_len + WIN_W'(1);
  end

  // Window update; strictly-greater keeps the earliest of equal-width windows.
  always_ff @(posedge sample_clk) begin
    if (reset || clear) begin
      run_start  <= '0;
      run_len    <= '0;
      best_start <= '0;
      best_len   <= '0;
    end else if (update) begin
      if (pass) begin
        run_start <= run_start_nxt;
        run_len   <= run_len_inc;
        if (run_len_inc > best_len) begin
          best_len   <= run_len_inc;
          best_start <= run_start_nxt;
        end
      end else begin
        run_len <= '0;
      end
    end
  end

  assign centre = centre_tap(best_start, best_len);

endmodule

// File: rtl/idelay_calib_sequencer.sv
// Per-lane IDELAY tap sweep and centre-of-eye load for the LTC2145 receiver.
// Latency: 32*(SETTLE_CYCLES+CHECK_CYCLES+2)+3 cycles per lane with RDY steady.
// No backpressure; losing idelayctrl_rdy mid-sweep restarts the current lane.
// Option IDELAY_CALIB_WINDOW_REPORT_EN adds the per-lane window_width report.
module idelay_calib_sequencer
  import idelay_calib_sequencer_pkg::*;
#(
  parameter int DATA_WIDTH    = 28,
  parameter int SETTLE_CYCLES = 16,
  parameter int CHECK_CYCLES  = 256,
  parameter int MIN_WINDOW    = 4,
  parameter int DEFAULT_TAP   = 16
) (
  input  logic                        sample_clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic                        idelayctrl_rdy,
  input  logic [DATA_WIDTH-1:0]       data_in,
  output logic [DATA_WIDTH-1:0]       delay_ld,
  output logic [DATA_WIDTH*TAP_W-1:0] delay_val_out,
  output logic                        busy,
  output logic                        done,
`ifdef IDELAY_CALIB_WINDOW_REPORT_EN
  output logic [DATA_WIDTH*WIN_W-1:0] window_width,
`endif
  output logic [DATA_WIDTH-1:0]       lane_fail
);

  localparam int LANE_W  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam int CNT_MAX = (SETTLE_CYCLES > CHECK_CYCLES) ? SETTLE_CYCLES : CHECK_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  cal_state_t       state;
  logic [LANE_W-1:0] lane;
  logic [TAP_W-1:0] tap;
  logic [CNT_W-1:0] cnt;
  logic             prev_bit;
  logic             err_flag;
  logic             trk_clear;
  logic             trk_update;
  logic [WIN_W-1:0] best_len;
  logic [TAP_W-1:0] centre;

  // Tracker is reset at the start of each lane sweep and fed once per tap.
  assign trk_clear  = (state == WAIT_RDY) && idelayctrl_rdy;
  assign trk_update = (state == EVAL) && idelayctrl_rdy;

  idelay_window_tracker u_tracker (
    .sample_clk (sample_clk),
    .reset      (reset),
    .clear      (trk_clear),
    .update     (trk_update),
    .pass       (!err_flag),
    .tap        (tap),
    .best_len   (best_len),
    .centre     (centre)
  );

  // Lane sequencing FSM with registered strobes and tap values.
  always_ff @(posedge sample_clk) begin
    if (reset) begin
      state         <= IDLE;
      lane          <= '0;
      tap           <= '0;
      cnt           <= '0;
      prev_bit      <= 1'b0;
      err_flag      <= 1'b0;
      delay_ld      <= '0;
      delay_val_out <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      lane_fail     <= '0;
`ifdef IDELAY_CALIB_WINDOW_REPORT_EN
      window_width  <= '0;
`endif
    end else begin
      delay_ld <= '0;
      case (state)
        IDLE: begin
          if (start) begin
            state     <= WAIT_RDY;
            busy      <= 1'b1;
            done      <= 1'b0;
            lane_fail <= '0;
            lane      <= '0;
`ifdef IDELAY_CALIB_WINDOW_REPORT_EN
            window_width <= '0;
`endif
          end
        end
        WAIT_RDY: begin
          if (idelayctrl_rdy) begin
            tap   <= '0;
            state <= LOAD;
          end
        end
        LOAD: begin
          if (!idelayctrl_rdy) begin
            state <= WAIT_RDY;
          end else begin
            delay_ld[lane]                        <= 1'b1;
            delay_val_out[lane*TAP_W +: TAP_W]    <= tap;
            cnt                                   <= '0;
            state                                 <= SETTLE;
          end
        end
        SETTLE: begin
          if (!idelayctrl_rdy) begin
            state <= WAIT_RDY;
          end else begin
            err_flag <= 1'b0;
            if (cnt == CNT_W'(SETTLE_CYCLES - 1)) begin
              cnt   <= '0;
              state <= CHECK;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        CHECK: begin
          if (!idelayctrl_rdy) begin
            state <= WAIT_RDY;
          end else begin
            // First cycle only seeds prev_bit; every later sample must differ.
            prev_bit <= data_in[lane];
            if ((cnt != '0) && (data_in[lane] == prev_bit))
              err_flag <= 1'b1;
            if (cnt == CNT_W'(CHECK_CYCLES - 1)) begin
              cnt   <= '0;
              state <= EVAL;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        EVAL: begin
          if (!idelayctrl_rdy) begin
            state <= WAIT_RDY;
          end else if (tap == TAP_W'(NUM_TAPS - 1)) begin
            state <= APPLY;
          end else begin
            tap   <= tap + 1'b1;
            state <= LOAD;
          end
        end
        APPLY: begin
          delay_ld[lane] <= 1'b1;
          if (best_len >= WIN_W'(MIN_WINDOW)) begin
            delay_val_out[lane*TAP_W +: TAP_W] <= centre;
          end else begin
            delay_val_out[lane*TAP_W +: TAP_W] <= TAP_W'(DEFAULT_TAP);
            lane_fail[lane]                    <= 1'b1;
          end
`ifdef IDELAY_CALIB_WINDOW_REPORT_EN
          window_width[lane*WIN_W +: WIN_W] <= best_len;
`endif
          state <= NEXT_LANE;
        end
        NEXT_LANE: begin
          if (lane == LANE_W'(DATA_WIDTH - 1)) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            lane  <= lane + 1'b1;
            state <= WAIT_RDY;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_idelay_calib_sequencer.sv
// Directed bench for idelay_calib_sequencer with a 2-lane, short-sweep configuration.
// Data lanes toggle only at taps inside each lane's pass mask.
// A per-cycle monitor checks delay_ld one-hotness and value/strobe alignment.
module tb_idelay_calib_sequencer;
  import idelay_calib_sequencer_pkg::*;

  localparam int DW = 2;
  localparam int EXP_CYCLES = 2 * (32 * 14 + 2) + 2;

  logic          sample_clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          idelayctrl_rdy = 1'b1;
  logic [DW-1:0] data_in = '0;
  logic [DW-1:0] delay_ld;
  logic [DW*5-1:0] delay_val_out;
  logic          busy;
  logic          done;
  logic [DW-1:0] lane_fail;
`ifdef IDELAY_CALIB_WINDOW_REPORT_EN
  logic [DW*6-1:0] window_width;
`endif

  int ntests = 0;
  int nfail  = 0;

  logic [31:0] mask0 = '0;
  logic [31:0] mask1 = '0;
  logic        tgl = 1'b0;
  logic        rst_q = 1'b1;
  logic [DW*5-1:0] val_q = '0;

  idelay_calib_sequencer #(
    .DATA_WIDTH(DW), .SETTLE_CYCLES(4), .CHECK_CYCLES(8), .MIN_WINDOW(4), .DEFAULT_TAP(16)
  ) dut (
    .sample_clk     (sample_clk),
    .reset          (reset),
    .start          (start),
    .idelayctrl_rdy (idelayctrl_rdy),
    .data_in        (data_in),
    .delay_ld       (delay_ld),
    .delay_val_out  (delay_val_out),
    .busy           (busy),
    .done           (done),
`ifdef IDELAY_CALIB_WINDOW_REPORT_EN
    .window_width   (window_width),
`endif
    .lane_fail      (lane_fail)
  );

  always #5 sample_clk = ~sample_clk;

  // ADC alternating-bit model: a lane toggles only when its loaded tap is in the mask.
  always @(posedge sample_clk) begin
    #1;
    tgl = ~tgl;
    data_in[0] = mask0[delay_val_out[4:0]] ? tgl : 1'b0;
    data_in[1] = mask1[delay_val_out[9:5]] ? tgl : 1'b0;
  end

  // Every cycle: at most one load strobe, and tap values only move with their strobe.
  always @(negedge sample_clk) begin
    ntests++;
    if ($countones(delay_ld) > 1) begin
      nfail++;
      $display("FAIL ld_onehot: delay_ld=%b, required popcount<=1", delay_ld);
    end
    for (int i = 0; i < DW; i++) begin
      if (!rst_q && (delay_val_out[i*5 +: 5] !== val_q[i*5 +: 5]) && (delay_ld[i] !== 1'b1)) begin
        nfail++;
        $display("FAIL ld_align lane%0d: value %0d->%0d with delay_ld=%b, required strobe",
                 i, val_q[i*5 +: 5], delay_val_out[i*5 +: 5], delay_ld);
      end
    end
    val_q = delay_val_out;
    rst_q = reset;
  end

  function automatic logic [31:0] range_mask(input int lo, input int hi);
    logic [31:0] m;
    m = '0;
    for (int t = lo; t <= hi; t++) m[t] = 1'b1;
    return m;
  endfunction

  // Idle gap, one start pulse, then wait (bounded) for done; cyc = -1 on timeout.
  task automatic do_run(output int cyc);
    repeat (2) @(posedge sample_clk);
    #1;
    start = 1'b1;
    @(posedge sample_clk); #1;
    start = 1'b0;
    cyc = 0;
    while (!done && cyc < 3000) begin
      @(posedge sample_clk); #1;
      cyc++;
    end
    if (!done) cyc = -1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(posedge sample_clk);
    #1;
    ntests++; if (delay_ld !== '0) begin nfail++; $display("FAIL rst_ld: got %b, required 0", delay_ld); end
    ntests++; if (delay_val_out !== '0) begin nfail++; $display("FAIL rst_val: got %h, required 0", delay_val_out); end
    ntests++; if (busy !== 1'b0 || done !== 1'b0) begin nfail++; $display("FAIL rst_busy_done: got %b%b, required 00", busy, done); end
    ntests++; if (lane_fail !== '0) begin nfail++; $display("FAIL rst_lane_fail: got %b, required 0", lane_fail); end
    reset = 1'b0;
  endtask

  task automatic test_basic;
    int cyc;
    mask0 = range_mask(10, 19);
    mask1 = range_mask(0, 31);
    do_run(cyc);
    ntests++; if (cyc != EXP_CYCLES) begin nfail++; $display("FAIL basic_cycles: got %0d, required %0d", cyc, EXP_CYCLES); end
    ntests++; if (delay_val_out[4:0] !== 5'd14) begin nfail++; $display("FAIL basic_lane0: got %0d, required 14", delay_val_out[4:0]); end
    ntests++; if (delay_val_out[9:5] !== 5'd15) begin nfail++; $display("FAIL basic_lane1: got %0d, required 15", delay_val_out[9:5]); end
    ntests++; if (lane_fail !== 2'b00) begin nfail++; $display("FAIL basic_lane_fail: got %b, required 00", lane_fail); end
    ntests++; if (busy !== 1'b0) begin nfail++; $display("FAIL basic_busy: got %b, required 0", busy); end
    repeat (3) @(posedge sample_clk);
    #1;
    ntests++; if (done !== 1'b1) begin nfail++; $display("FAIL basic_done_level: got %b, required 1", done); end
  endtask

  task automatic test_two_windows;
    int cyc;
    mask0 = range_mask(2, 4) | range_mask(20, 27);
    mask1 = range_mask(5, 8) | range_mask(12, 15);
    do_run(cyc);
    ntests++; if (cyc != EXP_CYCLES) begin nfail++; $display("FAIL win_cycles: got %0d, required %0d", cyc, EXP_CYCLES); end
    ntests++; if (delay_val_out[4:0] !== 5'd23) begin nfail++; $display("FAIL win_lane0: got %0d, required 23", delay_val_out[4:0]); end
    ntests++; if (delay_val_out[9:5] !== 5'd6) begin nfail++; $display("FAIL win_lane1_earliest: got %0d, required 6", delay_val_out[9:5]); end
  endtask

  task automatic test_lane_fail;
    int cyc;
    mask0 = range_mask(10, 19);
    mask1 = range_mask(0, 2);
    do_run(cyc);
    ntests++; if (lane_fail !== 2'b10) begin nfail++; $display("FAIL lf_flags: got %b, required 10", lane_fail); end
    ntests++; if (delay_val_out[9:5] !== 5'd16) begin nfail++; $display("FAIL lf_lane1_default: got %0d, required 16", delay_val_out[9:5]); end
    ntests++; if (delay_val_out[4:0] !== 5'd14) begin nfail++; $display("FAIL lf_lane0: got %0d, required 14", delay_val_out[4:0]); end
  endtask

  task automatic test_rdy_drop;
    int cyc;
    mask0 = range_mask(10, 19);
    mask1 = range_mask(0, 31);
    fork
      do_run(cyc);
      begin
        int k;
        k = 0;
        while (!(delay_ld[1] === 1'b1 && delay_val_out[9:5] === 5'd5) && k < 3000) begin
          @(posedge sample_clk); #1;
          k++;
        end
        ntests++; if (k >= 3000) begin nfail++; $display("FAIL rdy_find_tap5: got timeout, required lane1 tap5 load"); end
        repeat (6) @(posedge sample_clk);
        #1;
        idelayctrl_rdy = 1'b0;
        repeat (5) @(posedge sample_clk);
        #1;
        ntests++; if (delay_val_out[9:5] !== 5'd5) begin nfail++; $display("FAIL rdy_hold_val: got %0d, required 5", delay_val_out[9:5]); end
        idelayctrl_rdy = 1'b1;
        k = 0;
        while (delay_ld[1] !== 1'b1 && k < 100) begin
          @(posedge sample_clk); #1;
          k++;
        end
        ntests++; if (k >= 100 || delay_val_out[9:5] !== 5'd0) begin nfail++; $display("FAIL rdy_resweep: got tap %0d after %0d cycles, required tap 0", delay_val_out[9:5], k); end
      end
    join
    ntests++; if (cyc < 0) begin nfail++; $display("FAIL rdy_done: got timeout, required done"); end
    ntests++; if (delay_val_out[4:0] !== 5'd14 || delay_val_out[9:5] !== 5'd15) begin nfail++; $display("FAIL rdy_result: got %0d/%0d, required 14/15", delay_val_out[4:0], delay_val_out[9:5]); end
    ntests++; if (lane_fail !== 2'b00) begin nfail++; $display("FAIL rdy_lane_fail: got %b, required 00", lane_fail); end
  endtask

  task automatic test_start_busy_reset;
    int n;
    mask0 = range_mask(10, 19);
    mask1 = range_mask(0, 31);
    repeat (2) @(posedge sample_clk);
    #1;
    start = 1'b1;
    @(posedge sample_clk); #1;
    start = 1'b0;
    ntests++; if (busy !== 1'b1 || done !== 1'b0) begin nfail++; $display("FAIL sb_accept: got busy=%b done=%b, required 1/0", busy, done); end
    n = 0;
    while (!done && n < 3000) begin
      @(posedge sample_clk); #1;
      n++;
      start = (n == 100);
    end
    start = 1'b0;
    ntests++; if (n != EXP_CYCLES) begin nfail++; $display("FAIL sb_ignored_start: got %0d cycles, required %0d", n, EXP_CYCLES); end
    repeat (2) @(posedge sample_clk);
    #1;
    start = 1'b1;
    @(posedge sample_clk); #1;
    start = 1'b0;
    repeat (200) @(posedge sample_clk);
    #1;
    reset = 1'b1;
    @(posedge sample_clk); #1;
    ntests++; if (dut.state !== IDLE) begin nfail++; $display("FAIL mr_state: got %0d, required IDLE", dut.state); end
    ntests++; if (delay_val_out !== '0 || delay_ld !== '0) begin nfail++; $display("FAIL mr_outputs: got val=%h ld=%b, required 0", delay_val_out, delay_ld); end
    ntests++; if (busy !== 1'b0 || done !== 1'b0 || lane_fail !== '0) begin nfail++; $display("FAIL mr_flags: got busy=%b done=%b lf=%b, required 0", busy, done, lane_fail); end
    reset = 1'b0;
    repeat (3) @(posedge sample_clk);
    #1;
    ntests++; if (busy !== 1'b0) begin nfail++; $display("FAIL mr_stays_idle: got busy=%b, required 0", busy); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_two_windows();
    test_lane_fail();
    test_rdy_drop();
    test_start_busy_reset();
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
